// File: rtl/buzzer_pkg.sv
// Shared types, constants and the priority-select helper for the buzzer arbiter.
package buzzer_pkg;

   localparam int unsigned MAX_PLAYERS             = 16;
   localparam int unsigned PRIO_W                  = 4;
   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 100000;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ARMED    = 2'd1,
      ST_CAPTURED = 2'd2,
      ST_EXPIRED  = 2'd3
   } state_e;

   // First set bit at or after start, wrapping; unused upper mask bits must be zero,
   // which makes the 16-wide wrap behave like a wrap modulo the player count.
   function automatic logic [PRIO_W-1:0] onehot_prio(input logic [MAX_PLAYERS-1:0] mask,
                                                     input logic [PRIO_W-1:0]      start);
      logic [PRIO_W-1:0] idx;
      logic              found;
      onehot_prio = start;
      found       = 1'b0;
      for (int k = 0; k < MAX_PLAYERS; k++) begin
         idx = start + PRIO_W'(k);
         if (!found && mask[idx]) begin
            onehot_prio = idx;
            found       = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/btn_sync_debounce.sv
// One player button: 2-flop synchroniser, stability-counter debounce and a
// single-cycle press pulse on the debounced rising edge.
module btn_sync_debounce
   import buzzer_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw_i,
   output logic press_o
);

   localparam int unsigned     CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             deb_q, deb_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Count consecutive disagreeing cycles; flip on the last one, clear on any agreement.
   always_comb begin
      cnt_d = '0;
      deb_d = deb_q;
      if (sync2_q != deb_q) begin
         if (cnt_q == CNT_LAST) begin
            deb_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      press_d = deb_d & ~deb_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         deb_q   <= 1'b0;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= btn_raw_i;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/buzzer_arbiter.sv
// N-player buzzer front end: debounced buttons, armed-round arbitration, latched result.
// BUZZER_ROTATE_PRIORITY_EN selects round-robin tie-break instead of lowest index.
module buzzer_arbiter
   import buzzer_pkg::*;
#(
   parameter  int unsigned NUM_PLAYERS     = 4,
   parameter  int unsigned SW_WIDTH        = 8,
   parameter  int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter  int unsigned TIMEOUT_CYCLES  = 0,
   localparam int unsigned ID_WIDTH        = $clog2(NUM_PLAYERS)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_PLAYERS-1:0]          btn_raw,
   input  logic [NUM_PLAYERS*SW_WIDTH-1:0] sw_raw,
   input  logic                            arm,
   input  logic                            ack,
   output logic                            armed,
   output logic                            winner_valid,
   output logic [ID_WIDTH-1:0]             winner_id,
   output logic [SW_WIDTH-1:0]             winner_sw,
   output logic [NUM_PLAYERS-1:0]          contenders,
   output logic                            tie,
   output logic                            timeout
);

   localparam int unsigned      TCNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TCNT_W-1:0] TCNT_LAST  = TCNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic             TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

   logic [NUM_PLAYERS-1:0]          press;
   logic [NUM_PLAYERS*SW_WIDTH-1:0] sw_s1_q, sw_s2_q;
   logic [SW_WIDTH-1:0]             sw_bank [NUM_PLAYERS];

   for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
      btn_sync_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_btn (
         .clk      (clk),
         .rst      (rst),
         .btn_raw_i(btn_raw[g]),
         .press_o  (press[g])
      );
      assign sw_bank[g] = sw_s2_q[g*SW_WIDTH +: SW_WIDTH];
   end

   state_e                 state_q, state_d;
   logic [TCNT_W-1:0]      tcnt_q, tcnt_d;
   logic [ID_WIDTH-1:0]    id_q, id_d;
   logic [SW_WIDTH-1:0]    sw_q, sw_d;
   logic [NUM_PLAYERS-1:0] cont_q, cont_d;
   logic                   tie_q, tie_d;
   logic                   armed_q, valid_q, timeout_q;
   logic [PRIO_W-1:0]      prio_start, sel;
   logic [ID_WIDTH-1:0]    sel_id;

`ifdef BUZZER_ROTATE_PRIORITY_EN
   logic [ID_WIDTH-1:0] ptr_q, ptr_d;

   // Pointer advances past the winner on every capture.
   always_comb begin
      ptr_d = ptr_q;
      if (state_q == ST_ARMED && state_d == ST_CAPTURED) begin
         ptr_d = (sel_id == ID_WIDTH'(NUM_PLAYERS - 1)) ? '0 : sel_id + ID_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

   assign prio_start = PRIO_W'(ptr_q);
`else
   assign prio_start = '0;
`endif

   assign sel    = onehot_prio(MAX_PLAYERS'(press), prio_start);
   assign sel_id = ID_WIDTH'(sel);

   always_comb begin
      state_d = state_q;
      tcnt_d  = tcnt_q;
      id_d    = id_q;
      sw_d    = sw_q;
      cont_d  = cont_q;
      tie_d   = tie_q;
      case (state_q)
         ST_IDLE: begin
            if (arm) begin
               state_d = ST_ARMED;
               tcnt_d  = '0;
            end
         end
         ST_ARMED: begin
            // A press beats both a restart and an expiry in the same cycle.
            if (ack) begin
               state_d = ST_IDLE;
            end else if (|press) begin
               state_d = ST_CAPTURED;
               id_d    = sel_id;
               sw_d    = sw_bank[sel_id];
               cont_d  = press;
               tie_d   = ($countones(press) > 1);
            end else if (arm) begin
               tcnt_d = '0;
            end else if (TIMEOUT_EN && tcnt_q == TCNT_LAST) begin
               state_d = ST_EXPIRED;
            end else begin
               tcnt_d = tcnt_q + TCNT_W'(1);
            end
         end
         ST_CAPTURED: begin
            if (ack) begin
               state_d = ST_IDLE;
               id_d    = '0;
               sw_d    = '0;
               cont_d  = '0;
               tie_d   = 1'b0;
            end
         end
         ST_EXPIRED: begin
            if (ack) begin
               state_d = ST_IDLE;
            end else if (arm) begin
               state_d = ST_ARMED;
               tcnt_d  = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         tcnt_q    <= '0;
         id_q      <= '0;
         sw_q      <= '0;
         cont_q    <= '0;
         tie_q     <= 1'b0;
         armed_q   <= 1'b0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         sw_s1_q   <= '0;
         sw_s2_q   <= '0;
      end else begin
         state_q   <= state_d;
         tcnt_q    <= tcnt_d;
         id_q      <= id_d;
         sw_q      <= sw_d;
         cont_q    <= cont_d;
         tie_q     <= tie_d;
         armed_q   <= (state_d == ST_ARMED);
         valid_q   <= (state_d == ST_CAPTURED);
         timeout_q <= (state_d == ST_EXPIRED);
         sw_s1_q   <= sw_raw;
         sw_s2_q   <= sw_s1_q;
      end
   end

   assign armed        = armed_q;
   assign winner_valid = valid_q;
   assign winner_id    = id_q;
   assign winner_sw    = sw_q;
   assign contenders   = cont_q;
   assign tie          = tie_q;
   assign timeout      = timeout_q;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Self-checking bench: directed scenarios plus randomized rounds against a timing/priority model.
module tb_buzzer_arbiter;

   localparam int NP  = 4;
   localparam int SW  = 8;
   localparam int IDW = 2;
   localparam int DB  = 4;

   logic              clk, rst, arm, ack;
   logic [NP-1:0]     btn_raw;
   logic [NP*SW-1:0]  sw_raw;

   logic              a_armed, a_valid, a_tie, a_timeout;
   logic [IDW-1:0]    a_id;
   logic [SW-1:0]     a_sw;
   logic [NP-1:0]     a_cont;
   logic              t_armed, t_valid, t_tie, t_timeout;
   logic [IDW-1:0]    t_id;
   logic [SW-1:0]     t_sw;
   logic [NP-1:0]     t_cont;

   int checks  = 0;
   int errors  = 0;
   int ref_ptr = 0;

   buzzer_arbiter #(.NUM_PLAYERS(NP), .SW_WIDTH(SW), .DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(0)) dut (
      .clk(clk), .rst(rst), .btn_raw(btn_raw), .sw_raw(sw_raw), .arm(arm), .ack(ack),
      .armed(a_armed), .winner_valid(a_valid), .winner_id(a_id), .winner_sw(a_sw),
      .contenders(a_cont), .tie(a_tie), .timeout(a_timeout));

   buzzer_arbiter #(.NUM_PLAYERS(NP), .SW_WIDTH(SW), .DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(10)) dut_to (
      .clk(clk), .rst(rst), .btn_raw(btn_raw), .sw_raw(sw_raw), .arm(arm), .ack(ack),
      .armed(t_armed), .winner_valid(t_valid), .winner_id(t_id), .winner_sw(t_sw),
      .contenders(t_cont), .tie(t_tie), .timeout(t_timeout));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Spec-level priority: first contender found scanning upward from start, wrapping.
   function automatic int model_pick(input logic [NP-1:0] m, input int start);
      for (int k = 0; k < NP; k++) if (m[(start + k) % NP]) return (start + k) % NP;
      return -1;
   endfunction

   task automatic model_capture(input int w);
`ifdef BUZZER_ROTATE_PRIORITY_EN
      ref_ptr = (w + 1) % NP;
`else
      ref_ptr = (w >= 0) ? 0 : 0;
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; btn_raw = '0; arm = 1'b0; ack = 1'b0;
      tick();
      rst = 1'b0;
      ref_ptr = 0;
   endtask

   task automatic pulse_arm();
      arm = 1'b1; tick(); arm = 1'b0;
   endtask

   task automatic pulse_ack();
      ack = 1'b1; tick(); ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; btn_raw = '0; arm = 1'b1; ack = 1'b0; sw_raw = '1;
      repeat (3) tick();
      checks++; if ({a_armed, a_valid, a_timeout, a_tie} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {a_armed, a_valid, a_timeout, a_tie}); end
      checks++; if (a_id !== '0) begin errors++; $display("FAIL reset_id: got %0d want 0", a_id); end
      checks++; if (a_sw !== '0) begin errors++; $display("FAIL reset_sw: got %h want 00", a_sw); end
      checks++; if (a_cont !== '0) begin errors++; $display("FAIL reset_cont: got %b want 0000", a_cont); end
      arm = 1'b0; rst = 1'b0; sw_raw = '0;
      tick();
   endtask

   task automatic test_basic_win();
      do_reset();
      sw_raw[2*SW +: SW] = 8'hA5;
      repeat (3) tick();
      pulse_arm();
      checks++; if (a_armed !== 1'b1) begin errors++; $display("FAIL basic_armed: got %b want 1", a_armed); end
      btn_raw[2] = 1'b1;
      repeat (6) tick();
      checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL basic_early: valid got %b want 0 at cycle 6", a_valid); end
      tick();
      checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1 at cycle 7", a_valid); end
      checks++; if (a_id !== IDW'(2)) begin errors++; $display("FAIL basic_id: got %0d want 2", a_id); end
      checks++; if (a_sw !== 8'hA5) begin errors++; $display("FAIL basic_sw: got %h want a5", a_sw); end
      checks++; if ({a_cont, a_tie, a_armed} !== 6'b0100_0_0) begin errors++; $display("FAIL basic_cont_tie: got %b want 010000", {a_cont, a_tie, a_armed}); end
      pulse_ack();
      checks++; if ({a_valid, a_id, a_sw, a_cont, a_tie} !== '0) begin errors++; $display("FAIL basic_ack_clear: got %h want 0", {a_valid, a_id, a_sw, a_cont, a_tie}); end
      btn_raw = '0;
      repeat (10) tick();
      arm = 1'b1; ack = 1'b1; tick(); arm = 1'b0; ack = 1'b0;
      checks++; if (a_armed !== 1'b1) begin errors++; $display("FAIL idle_arm_ack: armed got %b want 1", a_armed); end
      pulse_ack();
      checks++; if (a_armed !== 1'b0) begin errors++; $display("FAIL armed_abort: armed got %b want 0", a_armed); end
   endtask

   task automatic test_bounce();
      do_reset();
      pulse_arm();
      for (int i = 0; i < 4; i++) begin
         btn_raw[1] = (i % 2 == 0);
         repeat (2) tick();
      end
      btn_raw[1] = 1'b0;
      repeat (20) tick();
      checks++; if ({a_valid, a_armed} !== 2'b01) begin errors++; $display("FAIL bounce: valid,armed got %b want 01", {a_valid, a_armed}); end
   endtask

   task automatic test_tie();
      int exp_id;
      do_reset();
      for (int round = 0; round < 2; round++) begin
         pulse_arm();
         btn_raw = 4'b1010;
         repeat (7) tick();
         exp_id = model_pick(4'b1010, ref_ptr);
         checks++; if ({a_valid, a_cont, a_tie} !== 6'b1_1010_1) begin errors++; $display("FAIL tie_mask r%0d: got %b want 110101", round, {a_valid, a_cont, a_tie}); end
         checks++; if (a_id !== IDW'(exp_id)) begin errors++; $display("FAIL tie_id r%0d: got %0d want %0d", round, a_id, exp_id); end
         model_capture(exp_id);
         pulse_ack();
         btn_raw = '0;
         repeat (10) tick();
      end
   endtask

   task automatic test_preheld();
      do_reset();
      btn_raw[0] = 1'b1;
      repeat (10) tick();
      pulse_arm();
      repeat (10) tick();
      checks++; if ({a_valid, a_armed} !== 2'b01) begin errors++; $display("FAIL preheld_lockout: valid,armed got %b want 01", {a_valid, a_armed}); end
      btn_raw[3] = 1'b1;
      repeat (7) tick();
      checks++; if ({a_valid, a_id, a_cont} !== {1'b1, 2'd3, 4'b1000}) begin errors++; $display("FAIL preheld_win: got %b want 1111000", {a_valid, a_id, a_cont}); end
      btn_raw[0] = 1'b0;
      repeat (10) tick();
      btn_raw[0] = 1'b1;
      repeat (10) tick();
      checks++; if ({a_valid, a_id, a_cont, a_tie} !== {1'b1, 2'd3, 4'b1000, 1'b0}) begin errors++; $display("FAIL captured_hold: got %b want 11110000", {a_valid, a_id, a_cont, a_tie}); end
   endtask

   task automatic test_timeout();
      do_reset();
      pulse_arm();
      repeat (9) tick();
      checks++; if ({t_timeout, t_armed} !== 2'b01) begin errors++; $display("FAIL timeout_early: timeout,armed got %b want 01", {t_timeout, t_armed}); end
      tick();
      checks++; if ({t_timeout, t_armed} !== 2'b10) begin errors++; $display("FAIL timeout_fire: timeout,armed got %b want 10", {t_timeout, t_armed}); end
      checks++; if ({a_timeout, a_armed} !== 2'b01) begin errors++; $display("FAIL timeout_disabled: timeout,armed got %b want 01", {a_timeout, a_armed}); end
      pulse_ack();
      checks++; if ({t_timeout, t_armed} !== 2'b00) begin errors++; $display("FAIL timeout_ack: timeout,armed got %b want 00", {t_timeout, t_armed}); end
      pulse_arm();
      repeat (10) tick();
      arm = 1'b1; ack = 1'b1; tick(); arm = 1'b0; ack = 1'b0;
      checks++; if ({t_timeout, t_armed} !== 2'b00) begin errors++; $display("FAIL expired_arm_ack: timeout,armed got %b want 00", {t_timeout, t_armed}); end
      pulse_arm();
      repeat (10) tick();
      pulse_arm();
      checks++; if ({t_timeout, t_armed} !== 2'b01) begin errors++; $display("FAIL expired_rearm: timeout,armed got %b want 01", {t_timeout, t_armed}); end
      do_reset();
      sw_raw[2*SW +: SW] = 8'h3C;
      repeat (3) tick();
      pulse_arm();
      repeat (3) tick();
      btn_raw[2] = 1'b1;
      repeat (6) tick();
      checks++; if ({t_valid, t_timeout} !== 2'b00) begin errors++; $display("FAIL expiry_cycle_pre: valid,timeout got %b want 00", {t_valid, t_timeout}); end
      tick();
      checks++; if ({t_valid, t_timeout, t_armed} !== 3'b100) begin errors++; $display("FAIL expiry_cycle_press: valid,timeout,armed got %b want 100", {t_valid, t_timeout, t_armed}); end
      checks++; if ({t_id, t_sw, t_cont, t_tie} !== {2'd2, 8'h3C, 4'b0100, 1'b0}) begin errors++; $display("FAIL expiry_cycle_result: got %h want %h", {t_id, t_sw, t_cont, t_tie}, {2'd2, 8'h3C, 4'b0100, 1'b0}); end
   endtask

   task automatic test_reset_mid_round();
      do_reset();
      pulse_arm();
      btn_raw[2] = 1'b1;
      repeat (7) tick();
      checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL midrst_setup: valid got %b want 1", a_valid); end
      rst = 1'b1; tick(); rst = 1'b0; ref_ptr = 0;
      checks++; if ({a_armed, a_valid, a_id, a_sw, a_cont, a_tie, a_timeout} !== '0) begin errors++; $display("FAIL midrst_clear: got %h want 0", {a_armed, a_valid, a_id, a_sw, a_cont, a_tie, a_timeout}); end
      repeat (10) tick();
      checks++; if ({a_valid, a_armed} !== 2'b00) begin errors++; $display("FAIL midrst_idle_press: valid,armed got %b want 00", {a_valid, a_armed}); end
      pulse_arm();
      btn_raw[0] = 1'b1;
      repeat (7) tick();
      checks++; if ({a_valid, a_id, a_cont} !== {1'b1, 2'd0, 4'b0001}) begin errors++; $display("FAIL midrst_rearm_win: got %b want 1000001", {a_valid, a_id, a_cont}); end
   endtask

   task automatic test_random();
      int             dly [NP];
      int             dmin, first, exp_first, exp_id;
      logic [NP-1:0]  exp_cont;
      logic [SW-1:0]  exp_sw;
      do_reset();
      for (int r = 0; r < 24; r++) begin
         btn_raw = '0;
         for (int i = 0; i < NP; i++) sw_raw[i*SW +: SW] = SW'($urandom);
         repeat (10) tick();
         dmin = 99;
         exp_cont = '0;
         for (int i = 0; i < NP; i++) begin
            dly[i] = ($urandom_range(0, 2) != 0) ? int'($urandom_range(0, 3)) : -1;
            if (dly[i] >= 0 && dly[i] < dmin) dmin = dly[i];
         end
         for (int i = 0; i < NP; i++) if (dly[i] == dmin) exp_cont[i] = 1'b1;
         pulse_arm();
         first = -1;
         for (int c = 0; c < 14; c++) begin
            for (int i = 0; i < NP; i++) if (dly[i] == c) btn_raw[i] = 1'b1;
            tick();
            if (a_valid === 1'b1 && first < 0) first = c + 1;
         end
         exp_first = (dmin == 99) ? -1 : dmin + DB + 3;
         checks++; if (first !== exp_first) begin errors++; $display("FAIL rand_latency r%0d: got %0d want %0d", r, first, exp_first); end
         if (dmin != 99) begin
            exp_id = model_pick(exp_cont, ref_ptr);
            exp_sw = sw_raw[exp_id*SW +: SW];
            checks++; if (a_id !== IDW'(exp_id)) begin errors++; $display("FAIL rand_id r%0d: got %0d want %0d", r, a_id, exp_id); end
            checks++; if (a_sw !== exp_sw) begin errors++; $display("FAIL rand_sw r%0d: got %h want %h", r, a_sw, exp_sw); end
            checks++; if ({a_cont, a_tie} !== {exp_cont, ($countones(exp_cont) > 1)}) begin errors++; $display("FAIL rand_cont r%0d: got %b want %b", r, {a_cont, a_tie}, {exp_cont, ($countones(exp_cont) > 1)}); end
            model_capture(exp_id);
         end else begin
            checks++; if (a_armed !== 1'b1) begin errors++; $display("FAIL rand_noarm r%0d: armed got %b want 1", r, a_armed); end
         end
         pulse_ack();
         checks++; if ({a_valid, a_armed, a_cont} !== '0) begin errors++; $display("FAIL rand_ack r%0d: got %b want 0", r, {a_valid, a_armed, a_cont}); end
      end
   endtask

   initial begin
      rst = 1'b1; arm = 1'b0; ack = 1'b0; btn_raw = '0; sw_raw = '0;
      test_reset();
      test_basic_win();
      test_bounce();
      test_tie();
      test_preheld();
      test_timeout();
      test_reset_mid_round();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
